// File: rtl/huffman_pkg.sv
// Shared types and alphabet rules for the Huffman symbol + extra-bit decoder.
package huffman_pkg;

  typedef enum logic [1:0] {
    MODE_LITLEN = 2'd0,
    MODE_DIST   = 2'd1,
    MODE_CLEN   = 2'd2
  } mode_e;

  typedef enum logic {
    ST_WALK  = 1'b0,
    ST_EXTRA = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int p = 1; p < v; p = p * 2) r++;
    return r;
  endfunction

  // Number of DEFLATE extra bits that follow a symbol of the given alphabet.
  function automatic logic [3:0] extra_bits(input mode_e mode, input int sym);
    logic [3:0] e;
    e = '0;
    case (mode)
      MODE_LITLEN: if (sym >= 265 && sym <= 284) e = 4'((sym - 261) >> 2);
      MODE_DIST:   if (sym >= 4 && sym <= 29) e = 4'((sym - 2) >> 1);
      MODE_CLEN: begin
        case (sym)
          16:      e = 4'd2;
          17:      e = 4'd3;
          18:      e = 4'd7;
          default: e = '0;
        endcase
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic invalid_sym(input mode_e mode, input int sym);
    logic bad;
    bad = 1'b0;
    case (mode)
      MODE_LITLEN: bad = (sym > 285);
      MODE_DIST:   bad = (sym > 29);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/huffman_extra_decoder_if.sv
// Bit-stream, tree-RAM and symbol-output signals of one decoder instance.
interface huffman_extra_decoder_if #(
  parameter int AW       = 10,
  parameter int OUTWIDTH = 10,
  parameter int EXTRAW   = 13
);
  logic                inew;
  logic                ien;
  logic                ibit;
  logic [AW-1:0]       rdaddr;
  logic [OUTWIDTH-1:0] rddata;
  logic                oen;
  logic [OUTWIDTH-1:0] ocode;
  logic [EXTRAW-1:0]   oextra;
  logic [3:0]          onbits;
  logic                oerr;

  modport master (
    output inew, ien, ibit, rddata,
    input  rdaddr, oen, ocode, oextra, onbits, oerr
  );

  modport slave (
    input  inew, ien, ibit, rddata,
    output rdaddr, oen, ocode, oextra, onbits, oerr
  );
endinterface

// File: rtl/huffman_extra_collect.sv
// Extra-bit collector: down-counter of remaining bits plus an insert register
// that places each arriving bit at the next position, first bit in bit 0.
module huffman_extra_collect
  import huffman_pkg::*;
#(
  parameter int EXTRAW = 13
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              load,
  input  logic [3:0]        load_n,
  input  logic              bit_en,
  input  logic              bit_in,
  output logic              done,
  output logic [EXTRAW-1:0] value,
  output logic [3:0]        nbits
);

  logic [3:0]        cnt, k, tot, rem, idx;
  logic [EXTRAW-1:0] sr;
  logic              take;

  // A load and the first bit may share a cycle, so everything is computed
  // from the post-load view.
  always_comb begin
    rem   = load ? load_n : cnt;
    idx   = load ? '0 : k;
    nbits = load ? load_n : tot;
    take  = bit_en && (rem != '0);
    value = load ? '0 : sr;
    for (int i = 0; i < EXTRAW; i++) begin
      if (take && (idx == 4'(i))) value[i] = bit_in;
    end
    done  = take && (rem == 4'd1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      k   <= '0;
      tot <= '0;
      sr  <= '0;
    end else if (clr) begin
      cnt <= '0;
      k   <= '0;
      tot <= '0;
      sr  <= '0;
    end else begin
      if (load) tot <= load_n;
      if (take) begin
        cnt <= rem - 4'd1;
        k   <= idx + 4'd1;
        sr  <= value;
      end else if (load) begin
        cnt <= load_n;
        k   <= '0;
        sr  <= '0;
      end
    end
  end

endmodule

// File: rtl/huffman_extra_decoder.sv
// Bit-serial canonical-Huffman tree walker that also gathers the extra bits
// following each symbol and reports {symbol, extra, count} in one beat.
//
// state    | meaning
// ST_WALK  | following tree bits from ntpos, RAM result valid when ienl
// ST_EXTRA | leaf found, collecting its extra bits into the collector
module huffman_extra_decoder
  import huffman_pkg::*;
#(
  parameter int MODE     = 0,
  parameter int NUMCODES = 288,
  parameter int OUTWIDTH = 10,
  parameter int EXTRAW   = 13
) (
  input logic                    clk,
  input logic                    rstn,
  huffman_extra_decoder_if.slave bus
);

  localparam int AW = clog2(2 * NUMCODES - 1);
  localparam int NW = AW - 1;
  localparam mode_e MODE_E = mode_e'(MODE);
  localparam logic [OUTWIDTH-1:0] NC       = OUTWIDTH'(NUMCODES);
  localparam logic [OUTWIDTH-1:0] NODE_LIM = OUTWIDTH'(2 * NUMCODES - 1);

  state_e              state;
  logic                ienl;
  logic [NW-1:0]       ntpos, node_cur;
  logic [OUTWIDTH-1:0] sym_q;
  logic                is_leaf, sym_bad, node_bad, err;
  logic                leaf_ok, go_extra, leaf_done0, tree_bit, bit_en;
  logic [3:0]          sym_e, nbits_n;
  logic                done;
  logic [EXTRAW-1:0]   val_n;

  // node_cur folds this cycle's RAM result in so a new bit can address the
  // next level without a bubble.
  always_comb begin
    is_leaf    = bus.rddata < NC;
    sym_e      = extra_bits(MODE_E, int'(bus.rddata));
    sym_bad    = is_leaf && invalid_sym(MODE_E, int'(bus.rddata));
    node_bad   = !is_leaf && (bus.rddata >= NODE_LIM);
    err        = ienl && (sym_bad || node_bad);
    leaf_ok    = ienl && is_leaf && !sym_bad;
    go_extra   = leaf_ok && (sym_e != '0);
    leaf_done0 = leaf_ok && (sym_e == '0);
    node_cur   = ntpos;
    if (ienl) node_cur = (is_leaf || node_bad) ? '0 : NW'(bus.rddata - NC);
    tree_bit   = bus.ien && (state == ST_WALK) && !go_extra;
    bit_en     = bus.ien && !bus.inew && (go_extra || (state == ST_EXTRA));
  end

  assign bus.rdaddr = {node_cur, bus.ibit};

  huffman_extra_collect #(
    .EXTRAW(EXTRAW)
  ) u_collect (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (bus.inew),
    .load   (go_extra && !bus.inew),
    .load_n (sym_e),
    .bit_en (bit_en),
    .bit_in (bus.ibit),
    .done   (done),
    .value  (val_n),
    .nbits  (nbits_n)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_WALK;
      ienl       <= 1'b0;
      ntpos      <= '0;
      sym_q      <= '0;
      bus.oen    <= 1'b0;
      bus.oerr   <= 1'b0;
      bus.ocode  <= '0;
      bus.oextra <= '0;
      bus.onbits <= '0;
    end else begin
      bus.oen  <= 1'b0;
      bus.oerr <= 1'b0;
      if (bus.inew) begin
        state <= ST_WALK;
        ienl  <= 1'b0;
        ntpos <= '0;
      end else begin
        ienl  <= tree_bit;
        ntpos <= node_cur;
        if (err) begin
          bus.oerr <= 1'b1;
          if (is_leaf) bus.ocode <= bus.rddata;
        end else if (leaf_done0) begin
          bus.oen    <= 1'b1;
          bus.ocode  <= bus.rddata;
          bus.oextra <= '0;
          bus.onbits <= '0;
        end else if (go_extra) begin
          sym_q <= bus.rddata;
          state <= ST_EXTRA;
        end
        // A one-bit extra field can finish in the same cycle the leaf arrives.
        if (done) begin
          bus.oen    <= 1'b1;
          bus.ocode  <= go_extra ? bus.rddata : sym_q;
          bus.oextra <= val_n;
          bus.onbits <= nbits_n;
          state      <= ST_WALK;
        end
      end
    end
  end

endmodule

// File: tb/tb_huffman_extra_decoder.sv
// Directed bench: distance, literal/length and code-length instances on
// small hand-built trees, a vector table plus timing and abort sequences.
module tb_huffman_extra_decoder;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  huffman_extra_decoder_if #(.AW(6),  .OUTWIDTH(10), .EXTRAW(13)) if_d ();
  huffman_extra_decoder_if #(.AW(10), .OUTWIDTH(10), .EXTRAW(13)) if_l ();
  huffman_extra_decoder_if #(.AW(6),  .OUTWIDTH(10), .EXTRAW(13)) if_c ();

  huffman_extra_decoder #(.MODE(1), .NUMCODES(32),  .OUTWIDTH(10), .EXTRAW(13))
    u_dist (.clk(clk), .rstn(rstn), .bus(if_d));
  huffman_extra_decoder #(.MODE(0), .NUMCODES(288), .OUTWIDTH(10), .EXTRAW(13))
    u_lit  (.clk(clk), .rstn(rstn), .bus(if_l));
  huffman_extra_decoder #(.MODE(2), .NUMCODES(19),  .OUTWIDTH(10), .EXTRAW(13))
    u_clen (.clk(clk), .rstn(rstn), .bus(if_c));

  logic [9:0] ram_d [64];
  logic [9:0] ram_l [1024];
  logic [9:0] ram_c [64];

  always @(posedge clk) begin
    if_d.rddata <= ram_d[if_d.rdaddr];
    if_l.rddata <= ram_l[if_l.rdaddr];
    if_c.rddata <= ram_c[if_c.rdaddr];
  end

  // index 0 = distance, 1 = literal/length, 2 = code-length
  logic inew_v [3];
  logic ien_v  [3];
  logic ibit_v [3];

  assign if_d.inew = inew_v[0];
  assign if_d.ien  = ien_v[0];
  assign if_d.ibit = ibit_v[0];
  assign if_l.inew = inew_v[1];
  assign if_l.ien  = ien_v[1];
  assign if_l.ibit = ibit_v[1];
  assign if_c.inew = inew_v[2];
  assign if_c.ien  = ien_v[2];
  assign if_c.ibit = ibit_v[2];

  logic oen_w  [3];
  logic oerr_w [3];
  int   code_w [3];
  int   extra_w[3];
  int   nb_w   [3];

  assign oen_w[0]   = if_d.oen;
  assign oen_w[1]   = if_l.oen;
  assign oen_w[2]   = if_c.oen;
  assign oerr_w[0]  = if_d.oerr;
  assign oerr_w[1]  = if_l.oerr;
  assign oerr_w[2]  = if_c.oerr;
  assign code_w[0]  = int'(if_d.ocode);
  assign code_w[1]  = int'(if_l.ocode);
  assign code_w[2]  = int'(if_c.ocode);
  assign extra_w[0] = int'(if_d.oextra);
  assign extra_w[1] = int'(if_l.oextra);
  assign extra_w[2] = int'(if_c.oextra);
  assign nb_w[0]    = int'(if_d.onbits);
  assign nb_w[1]    = int'(if_l.onbits);
  assign nb_w[2]    = int'(if_c.onbits);

  int oen_cnt [3] = '{0, 0, 0};
  int oerr_cnt[3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (oen_w[i])  oen_cnt[i]  = oen_cnt[i] + 1;
      if (oerr_w[i]) oerr_cnt[i] = oerr_cnt[i] + 1;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic drive(input int i, input logic en, input logic b, input logic nw);
    @(posedge clk);
    #1;
    ien_v[i]  = en;
    ibit_v[i] = b;
    inew_v[i] = nw;
  endtask

  task automatic idle(input int i, input int n);
    repeat (n) drive(i, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    int          inst;
    int          len;
    logic [31:0] bits;
    bit          is_err;
    int          code;
    int          extra;
    int          nb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          be, br;
    logic [12:0] xv;

    for (int i = 0; i < 3; i++) begin
      inew_v[i] = 1'b0;
      ien_v[i]  = 1'b0;
      ibit_v[i] = 1'b0;
    end
    for (int a = 0; a < 64; a++) begin
      ram_d[a] = 10'd63;
      ram_c[a] = 10'd63;
    end
    for (int a = 0; a < 1024; a++) ram_l[a] = 10'd1023;
    ram_d[0] = 10'd4;   ram_d[1] = 10'd33;  ram_d[2] = 10'd29;  ram_d[3] = 10'd30;
    ram_l[0] = 10'd256; ram_l[1] = 10'd289; ram_l[2] = 10'd265; ram_l[3] = 10'd286;
    ram_c[0] = 10'd18;  ram_c[1] = 10'd20;  ram_c[2] = 10'd3;   ram_c[3] = 10'd16;

    vecs[0] = '{0, 2,  32'b10,                    1'b0, 4,   1,       1};
    vecs[1] = '{0, 15, (32'h1ABC << 2) | 32'd1,   1'b0, 29,  'h1ABC,  13};
    vecs[2] = '{0, 2,  32'b11,                    1'b1, 30,  0,       0};
    vecs[3] = '{0, 2,  32'b00,                    1'b0, 4,   0,       1};
    vecs[4] = '{1, 1,  32'b0,                     1'b0, 256, 0,       0};
    vecs[5] = '{1, 3,  32'b101,                   1'b0, 265, 1,       1};
    vecs[6] = '{1, 2,  32'b11,                    1'b1, 286, 0,       0};
    vecs[7] = '{2, 8,  32'h4D << 1,               1'b0, 18,  'h4D,    7};
    vecs[8] = '{2, 2,  32'b01,                    1'b0, 3,   0,       0};
    vecs[9] = '{2, 4,  32'b1111,                  1'b0, 16,  3,       2};

    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_oen[%0d]", i),    int'(oen_w[i]),  0);
      chk($sformatf("reset_oerr[%0d]", i),   int'(oerr_w[i]), 0);
      chk($sformatf("reset_ocode[%0d]", i),  code_w[i],       0);
      chk($sformatf("reset_oextra[%0d]", i), extra_w[i],      0);
      chk($sformatf("reset_onbits[%0d]", i), nb_w[i],         0);
    end
    rstn = 1'b1;

    for (int v = 0; v < 10; v++) begin
      be = oen_cnt[vecs[v].inst];
      br = oerr_cnt[vecs[v].inst];
      for (int k = 0; k < vecs[v].len; k++) drive(vecs[v].inst, 1'b1, vecs[v].bits[k], 1'b0);
      idle(vecs[v].inst, 4);
      if (vecs[v].is_err) begin
        chk($sformatf("vec%0d_oerr_count", v), oerr_cnt[vecs[v].inst] - br, 1);
        chk($sformatf("vec%0d_oen_count", v),  oen_cnt[vecs[v].inst] - be,  0);
        chk($sformatf("vec%0d_ocode", v),      code_w[vecs[v].inst], vecs[v].code);
      end else begin
        chk($sformatf("vec%0d_oen_count", v),  oen_cnt[vecs[v].inst] - be,  1);
        chk($sformatf("vec%0d_oerr_count", v), oerr_cnt[vecs[v].inst] - br, 0);
        chk($sformatf("vec%0d_ocode", v),      code_w[vecs[v].inst],  vecs[v].code);
        chk($sformatf("vec%0d_oextra", v),     extra_w[vecs[v].inst], vecs[v].extra);
        chk($sformatf("vec%0d_onbits", v),     nb_w[vecs[v].inst],    vecs[v].nb);
      end
    end

    // E = 0 latency: code bit in cycle t, oen in t+2 only
    drive(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk) chk("lit_lat_t0", int'(oen_w[1]), 0);
    drive(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk) chk("lit_lat_t1", int'(oen_w[1]), 0);
    drive(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk) chk("lit_lat_t2", int'(oen_w[1]), 1);
    drive(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk) begin
      chk("lit_lat_t3", int'(oen_w[1]), 0);
      chk("lit_hold_code", code_w[1], 256);
    end

    // back-to-back root leaves: one symbol per cycle
    be = oen_cnt[1];
    repeat (4) drive(1, 1'b1, 1'b0, 1'b0);
    idle(1, 4);
    chk("lit_b2b_count", oen_cnt[1] - be, 4);

    // E > 0 latency: last extra bit in cycle u, oen in u+1
    drive(0, 1'b1, 1'b0, 1'b0);
    @(negedge clk) chk("dist_lat_t", int'(oen_w[0]), 0);
    drive(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk) chk("dist_lat_u", int'(oen_w[0]), 0);
    drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) begin
      chk("dist_lat_u1", int'(oen_w[0]), 1);
      chk("dist_lat_extra", extra_w[0], 1);
    end
    idle(0, 2);

    // 13 extra bits with random gaps
    xv = 13'h1ABC;
    be = oen_cnt[0];
    drive(0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) begin
      repeat ($urandom_range(0, 2)) drive(0, 1'b0, 1'b0, 1'b0);
      drive(0, 1'b1, xv[k], 1'b0);
    end
    idle(0, 4);
    chk("gap_oen_count", oen_cnt[0] - be, 1);
    chk("gap_ocode",     code_w[0],  29);
    chk("gap_oextra",    extra_w[0], 'h1ABC);
    chk("gap_onbits",    nb_w[0],    13);

    // inew mid-EXTRA (with a bit on the same cycle), then reset mid-walk
    be = oen_cnt[0];
    br = oerr_cnt[0];
    drive(0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) drive(0, 1'b1, xv[k], 1'b0);
    drive(0, 1'b1, 1'b1, 1'b1);
    drive(0, 1'b1, 1'b1, 1'b0);
    idle(0, 3);
    chk("inew_no_oen",  oen_cnt[0] - be,  0);
    chk("inew_no_oerr", oerr_cnt[0] - br, 0);
    drive(0, 1'b1, 1'b1, 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b1, 1'b0);
    idle(0, 4);
    chk("abort_oen_count",  oen_cnt[0] - be,  1);
    chk("abort_oerr_count", oerr_cnt[0] - br, 0);
    chk("abort_ocode",      code_w[0],  4);
    chk("abort_oextra",     extra_w[0], 1);
    chk("abort_onbits",     nb_w[0],    1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/huffman_extra_decoder.md
# huffman_extra_decoder

Bit-serial canonical-Huffman symbol decoder for the PNG inflate path that walks a tree stored in an external synchronous RAM and, in the same pass, collects the DEFLATE extra bits that follow each symbol. One instance per alphabet: a `MODE` parameter selects literal/length, distance or code-length extra-bit rules. It replaces bare symbol decoders plus separate extra-bit shifters, and hands `{symbol, extra value, extra count}` to the LZ77 back-end in one registered beat.

## Interface
- `MODE`, 0: extra-bit rule; 0 = literal/length, 1 = distance, 2 = code-length alphabet.
- `NUMCODES`, 288: alphabet size; tree RAM holds `2*NUMCODES` entries.
- `OUTWIDTH`, 10: RAM data and symbol width.
- `EXTRAW`, 13: extra-value width; must be ≥ 13 for `MODE`=1 and ≥ 7 otherwise.
- `AW`, derived: `clog2(2*NUMCODES-1)`; this is the RAM address width.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: asynchronous active-low reset.
- `inew`  in  1: start of new table; synchronous clear of walk and extra state.
- `ien`  in  1: `ibit` valid this cycle.
- `ibit`  in  1: stream bit, LSB-first DEFLATE order.
- `rdaddr`  out  AW: tree RAM read address `{node, bit}`, combinational.
- `rddata`  in  OUTWIDTH: RAM read data, one cycle after `rdaddr`.
- `oen`  out  1: registered one-cycle pulse, symbol complete.
- `ocode`  out  OUTWIDTH: decoded symbol.
- `oextra`  out  EXTRAW: extra-bit value, first received bit in bit 0.
- `onbits`  out  4: number of extra bits consumed (0–13).
- `oerr`  out  1: registered one-cycle pulse on invalid node or symbol.

## Operation
- Tree entry encoding:
  - `rddata < NUMCODES` means a leaf holding that symbol.
  - Otherwise the entry is an internal node with index `rddata - NUMCODES`.
  - The root is node 0.
- States are WALK and EXTRA. The `ienl` flag is the registered `ien`, and a RAM result is only meaningful while `ienl` = 1.
- In WALK, `ntpos` is the current node. It becomes 0 when the RAM returns a leaf. `rdaddr = {ntpos, ibit}`.
- Leaf handling, on the cycle with `ienl` = 1 and a leaf in `rddata`:
  - Compute E from the table below.
  - If E = 0, register `oen` next edge and stay in WALK.
  - If E > 0, store the symbol, set the remaining count to E and enter EXTRA.
  - If `ien` is also high that cycle, its bit is the first extra bit and is not a tree bit.
- EXTRA:
  - Each `ien` bit is written to `oextra[k]`, where k counts up from 0.
  - After bit E-1, pulse `oen` and return to WALK at node 0.
  - Gaps in `ien` are allowed in any state.
- Extra-bit table:
  - MODE 0: symbols 0–264 and 285 take 0; symbols 265–284 take (s-261)>>2.
  - MODE 1: symbols 0–3 take 0; symbols 4–29 take (s-2)>>1.
  - MODE 2: symbols 0–15 take 0; 16 takes 2, 17 takes 3, 18 takes 7.
- Errors:
  - An invalid symbol (MODE 0: 286/287; MODE 1: 30/31) pulses `oerr` with `ocode` set to the symbol.
  - A node index ≥ NUMCODES-1 also pulses `oerr`.
  - Either error returns the walk to the root. `oen` stays low.
- `inew` has priority over everything:
  - Clears node, state, count and `ienl`.
  - Any bit presented in the same cycle is dropped.
  - Produces no `oen` or `oerr` for the abandoned symbol.

## Timing
- Reset values: `oen`=0, `oerr`=0, `ocode`=0, `oextra`=0, `onbits`=0, node=0, state WALK.
- With E = 0, the last code bit in cycle t gives `oen` at t+2.
- With E > 0, the last extra bit in cycle u gives `oen` at u+1.
- The walk accepts one bit per cycle sustained, with no stall.
- Outputs hold until the next `oen`/`oerr`. Only the pulses return to 0.
- Reset mid-EXTRA aborts silently.

## Structure
- The package `huffman_pkg` holds:
  - the `MODE` enum;
  - the state typedef;
  - the `extra_bits(mode, sym)` function;
  - the invalid-symbol function;
  - the `clog2` function.
- Sub-module `huffman_extra_collect`: the counter and shift/insert register for extra bits, with `load(E)`, `bit` and `done` ports.

## Test plan
All scenarios use a RAM model with 1-cycle latency. Tree for MODE 1 / NUMCODES 32: root `0`→4, root `1`→33 (node 1); node 1 `0`→29, `1`→30.
- Bits 0, 1 → `oen`, `ocode`=4, `oextra`=1, `onbits`=1, one cycle after the second bit.
- Bits 1, 0, then 13 bits of 0x1ABC (LSB first) with random `ien` gaps → `ocode`=29, `oextra`=0x1ABC, `onbits`=13.
- Bits 1, 1 → `oerr` pulse with `ocode`=30, no `oen`. The next bits 0, 0 decode symbol 4, `oextra`=0.
- MODE 0, tree root `0`→256 → `oen` at t+2, `ocode`=256, `onbits`=0; back-to-back bits yield one symbol per cycle.
- MODE 2, leaf 18 then bits 1,0,1,1,0,0,1 → `ocode`=18, `oextra`=0x4D, `onbits`=7.
- `inew` after 5 of 13 extra bits, then a `rstn` pulse mid-walk → no `oen`; the next symbol decodes correctly from the root.
